fifo_drain_ctrl: RTL

//  Read-side controller for MyFIFO: owns enable_read and turns value_to_read into a valid/ready stream.

---
 rtl/fifo_drain_ctrl.sv | 118 +++++++++++
 1 files changed

// File: rtl/fifo_drain_ctrl.sv
// fifo_drain_ctrl: read-side controller for MyFIFO with a mirrored level counter and an output skid buffer.
// Define FIFO_DRAIN_STATS_EN to add the saturating drop_cnt output.
module fifo_drain_ctrl #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 4,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_wr_en,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_rd_data,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [CNT_W-1:0]  level,
  output logic              empty,
  output logic              full
`ifdef FIFO_DRAIN_STATS_EN
  ,
  output logic [15:0]       drop_cnt
`endif
);

  localparam int SKID = RD_LAT + 1;
  localparam int PW   = $clog2(SKID);
  localparam int BW   = $clog2(SKID + 1);
  localparam int OW   = BW + 1;

  logic [CNT_W-1:0]  level_q, level_d;
  logic [RD_LAT-1:0] infl_q, infl_d;
  logic [DATA_W-1:0] mem_q [SKID];
  logic [DATA_W-1:0] mem_d [SKID];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [BW-1:0]     buf_cnt_q, buf_cnt_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic              m_valid_q;
  logic [OW-1:0]     infl_cnt, occ;
  logic              pop, cap, wr_acc, rd_en;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(SKID - 1)) return '0;
    return p + 1'b1;
  endfunction

  always_comb begin
    infl_cnt = '0;
    for (int i = 0; i < RD_LAT; i++) infl_cnt = infl_cnt + OW'(infl_q[i]);
  end

  assign pop = m_valid_q && m_ready;
  assign cap = infl_q[RD_LAT-1];
  // Slots already committed (held + still in flight) after this cycle's pop.
  assign occ = OW'(buf_cnt_q) + infl_cnt - OW'(pop);
  assign rd_en = !rst && (level_q != '0) && (occ < OW'(SKID));
  assign wr_acc = fifo_wr_en && ((level_q < CNT_W'(DEPTH)) || rd_en);
  assign level_d = level_q + CNT_W'(wr_acc) - CNT_W'(rd_en);

  always_comb begin
    infl_d[0] = rd_en;
    for (int i = 1; i < RD_LAT; i++) infl_d[i] = infl_q[i-1];
  end

  always_comb begin
    mem_d = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (cap) begin
      mem_d[wr_ptr_q] = fifo_rd_data;
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    buf_cnt_d = buf_cnt_q + BW'(cap) - BW'(pop);
    m_data_d = mem_d[rd_ptr_d];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level_q   <= '0;
      infl_q    <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      buf_cnt_q <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      for (int i = 0; i < SKID; i++) mem_q[i] <= '0;
    end else begin
      level_q   <= level_d;
      infl_q    <= infl_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      buf_cnt_q <= buf_cnt_d;
      m_valid_q <= (buf_cnt_d != '0);
      m_data_q  <= m_data_d;
      mem_q     <= mem_d;
    end
  end

`ifdef FIFO_DRAIN_STATS_EN
  logic [15:0] drop_q;

  always_ff @(posedge clk) begin
    if (rst) drop_q <= '0;
    else if (fifo_wr_en && !wr_acc && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'd1;
  end

  assign drop_cnt = drop_q;
`endif

  assign fifo_rd_en = rd_en;
  assign m_data     = m_data_q;
  assign m_valid    = m_valid_q;
  assign level      = level_q;
  assign empty      = (level_q == '0);
  assign full       = (level_q == CNT_W'(DEPTH));

endmodule
